// File: rtl/base_pkg.sv
// Shared helpers for the base_ cell family.
package base_pkg;

    localparam int unsigned MinTimerWidth = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Width of a counter that must hold 0..n inclusive.
    function automatic int unsigned timer_width(input int unsigned n);
        int unsigned w;
        w = clog2(n + 1);
        return (w < MinTimerWidth) ? MinTimerWidth : w;
    endfunction

endpackage

// File: rtl/base_aoreg.sv
// Single-entry valid/ready output register with load/pop semantics.
module base_aoreg #(
    parameter int unsigned width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_d,
    input  logic             ready,
    output logic             valid,
    output logic [width-1:0] data
);

    // A load takes priority over a pop so the slot can reload back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/base_achange.sv
// Change filter: forwards a sample only when it differs from the last one sent,
// with an optional keep-alive refresh of the held value after an idle period.
module base_achange
    import base_pkg::*;
#(
    parameter int unsigned width          = 1,
    parameter int unsigned refresh_cycles = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             i_r,
    input  logic             i_v,
    input  logic [0:width-1] i_d,
    input  logic             o_r,
    output logic             o_v,
    output logic [0:width-1] o_d,
    output logic             o_refresh
);

    localparam int unsigned           TimerW    = timer_width(refresh_cycles);
    localparam logic [TimerW-1:0]     TimerMax  = TimerW'(refresh_cycles);
    localparam bit                    RefreshEn = (refresh_cycles != 0);

    logic                have_ref;
    logic [0:width-1]    ref_d;
    logic [TimerW-1:0]   timer;

    logic                slot_v;
    logic [width:0]      slot_q;
    logic                slot_free;
    logic                accept;
    logic                change;
    logic                refresh;
    logic                load;
    logic [width:0]      load_d;

    always_comb begin
        slot_free = !slot_v || o_r;
        i_r       = !reset && slot_free;
        accept    = i_v && i_r;
        change    = accept && (!have_ref || (i_d != ref_d));
        // A genuine change always beats a pending refresh.
        refresh   = RefreshEn && have_ref && (timer == TimerMax) && slot_free && !change;
        load      = change || refresh;
        load_d    = change ? {i_d, 1'b0} : {ref_d, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            have_ref <= 1'b0;
            ref_d    <= '0;
            timer    <= '0;
        end else begin
            if (change) begin
                have_ref <= 1'b1;
                ref_d    <= i_d;
            end
            if (load) begin
                timer <= '0;
            end else if (RefreshEn && have_ref && (timer != TimerMax)) begin
                timer <= timer + TimerW'(1);
            end
        end
    end

    base_aoreg #(
        .width(width + 1)
    ) u_oreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .load_d(load_d),
        .ready (o_r),
        .valid (slot_v),
        .data  (slot_q)
    );

    assign o_v       = slot_v;
    assign o_d       = slot_q[width:1];
    assign o_refresh = slot_q[0];

endmodule

// File: tb/tb_base_achange.sv
// Directed bench for base_achange: dut a has refresh disabled, dut b refreshes every 4 idle cycles.
module tb_base_achange;

    logic       clk;
    logic       reset;
    logic       a_ir, a_iv, a_or, a_ov, a_rf;
    logic [0:7] a_id, a_od;
    logic       b_ir, b_iv, b_or, b_ov, b_rf;
    logic [0:7] b_id, b_od;

    int tests;
    int fails;

    base_achange #(.width(8), .refresh_cycles(0)) dut_a (
        .clk(clk), .reset(reset), .i_r(a_ir), .i_v(a_iv), .i_d(a_id),
        .o_r(a_or), .o_v(a_ov), .o_d(a_od), .o_refresh(a_rf)
    );

    base_achange #(.width(8), .refresh_cycles(4)) dut_b (
        .clk(clk), .reset(reset), .i_r(b_ir), .i_v(b_iv), .i_d(b_id),
        .o_r(b_or), .o_v(b_ov), .o_d(b_od), .o_refresh(b_rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1_d  [5] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11};
    logic       t1_ov [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        a_iv = 1'b0; a_id = 8'h00; a_or = 1'b1;
        b_iv = 1'b0; b_id = 8'h00; b_or = 1'b1;
        cyc();
        cyc();
        chk("rst_a_ir", a_ir, 0);
        chk("rst_b_ir", b_ir, 0);
        chk("rst_b_ov", b_ov, 0);
        chk("rst_b_od", b_od, 0);
        chk("rst_b_rf", b_rf, 0);
        chk("rst_a_ov", a_ov, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_a_ir", a_ir, 1);
        chk("post_rst_b_ir", b_ir, 1);

        // 1: change filtering with refresh disabled
        for (int i = 0; i < 5; i++) begin
            a_iv = 1'b1;
            a_id = t1_d[i];
            #1;
            chk("t1_ir", a_ir, 1);
            cyc();
            chk("t1_ov", a_ov, 32'(t1_ov[i]));
            if (t1_ov[i]) begin
                chk("t1_od", a_od, 32'(t1_d[i]));
                chk("t1_rf", a_rf, 0);
            end
        end
        a_iv = 1'b0;

        // 2: single value then periodic refresh at cycles 6, 11, 16
        b_iv = 1'b1; b_id = 8'h5A;
        cyc();
        chk("t2_first_ov", b_ov, 1);
        chk("t2_first_od", b_od, 32'h5A);
        chk("t2_first_rf", b_rf, 0);
        b_iv = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            cyc();
            chk("t2_ov", b_ov, (c == 6 || c == 11 || c == 16) ? 1 : 0);
            chk("t2_a_idle", a_ov, 0);
            if (c == 6 || c == 11 || c == 16) begin
                chk("t2_od", b_od, 32'h5A);
                chk("t2_rf", b_rf, 1);
            end
        end

        // 3: redundant stream, change presented when refresh is due
        b_iv = 1'b1; b_id = 8'h5A;
        for (int c = 17; c <= 20; c++) begin
            cyc();
            chk("t3_drop_ov", b_ov, 0);
        end
        b_id = 8'h7E;
        cyc();
        chk("t3_chg_ov", b_ov, 1);
        chk("t3_chg_od", b_od, 32'h7E);
        chk("t3_chg_rf", b_rf, 0);
        b_iv = 1'b0;
        for (int c = 22; c <= 25; c++) begin
            cyc();
            chk("t3_idle_ov", b_ov, 0);
        end
        cyc();
        chk("t3_ref_ov", b_ov, 1);
        chk("t3_ref_od", b_od, 32'h7E);
        chk("t3_ref_rf", b_rf, 1);

        // 4: backpressure holds 0x33, refresh follows the pop
        b_iv = 1'b1; b_id = 8'h33;
        cyc();
        b_or = 1'b0; b_id = 8'h99;
        #1;
        chk("t4_ir", b_ir, 0);
        chk("t4_ov", b_ov, 1);
        chk("t4_od", b_od, 32'h33);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("t4_hold_ir", b_ir, 0);
            chk("t4_hold_ov", b_ov, 1);
            chk("t4_hold_od", b_od, 32'h33);
            chk("t4_hold_rf", b_rf, 0);
        end
        b_or = 1'b1; b_iv = 1'b0;
        #1;
        chk("t4_rel_ir", b_ir, 1);
        chk("t4_rel_rf", b_rf, 0);
        cyc();
        chk("t4_ref_ov", b_ov, 1);
        chk("t4_ref_od", b_od, 32'h33);
        chk("t4_ref_rf", b_rf, 1);

        // 5: reset while holding 0x44, then 0x44 is forwarded again
        b_iv = 1'b1; b_id = 8'h44;
        cyc();
        b_iv = 1'b0; b_or = 1'b0;
        chk("t5_pre_od", b_od, 32'h44);
        reset = 1'b1;
        #1;
        chk("t5_rst_ir", b_ir, 0);
        cyc();
        chk("t5_rst_ov", b_ov, 0);
        chk("t5_rst_od", b_od, 0);
        reset = 1'b0; b_or = 1'b1; b_iv = 1'b1; b_id = 8'h44;
        #1;
        chk("t5_ir", b_ir, 1);
        cyc();
        chk("t5_ov", b_ov, 1);
        chk("t5_od", b_od, 32'h44);
        chk("t5_rf", b_rf, 0);

        // 6: back-to-back distinct values, no bubbles
        for (int i = 1; i <= 3; i++) begin
            b_id = 8'(i);
            cyc();
            chk("t6_ov", b_ov, 1);
            chk("t6_od", b_od, 32'(i));
            chk("t6_rf", b_rf, 0);
        end
        b_iv = 1'b0;
        cyc();
        chk("t6_end_ov", b_ov, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/base_achange.md
Name: base_achange

Overview:
- Change-filtering stage that sits directly downstream of a latest-value latch.
- Consumes a valid/ready stream of sampled values and forwards a value only when it differs from the last value forwarded.
- Optionally re-sends the held value after a programmable idle period as a keep-alive refresh.
- Has one registered output slot, so it preserves backpressure and drops redundant samples.

Parameters:
- width, 1, data width in bits.
- refresh_cycles, 0, idle cycles before a refresh re-send; 0 disables refresh.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- i_r  output  1  input ready
- i_v  input  1  input valid
- i_d  input  [0:width-1]  input data
- o_r  input  1  output ready
- o_v  output  1  output valid
- o_d  output  [0:width-1]  output data
- o_refresh  output  1  qualifies o_d while o_v=1: 1 = refresh re-send, 0 = genuine change

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. All state updates on the rising edge of clk.
- Reset values:
  - o_v=0, o_d=0, o_refresh=0.
  - have_ref=0, ref_d=0, timer=0.
  - i_r=0 while reset is high.
- i_r = !reset && (!o_v || o_r). This is combinational; there is no skid.
- Accept occurs when i_v && i_r. Every accepted beat is consumed, whether or not it is forwarded.
- Change emission, on accept when !have_ref or i_d != ref_d:
  - Load the output slot with i_d and o_refresh=0.
  - Update ref_d to i_d, set have_ref to 1, clear timer to 0.
- Redundant drop, on accept when have_ref and i_d == ref_d: no output, no state change except the timer.
- Latency: accept at edge t gives o_v=1 in the cycle after t. o_v/o_d/o_refresh are held stable until o_v && o_r.
- Timer:
  - Runs only when refresh_cycles>0 and have_ref=1.
  - Increments by 1 per cycle and saturates at refresh_cycles.
  - Clears on any emission. Its width is clog2(refresh_cycles+1), minimum 1.
- Refresh emission:
  - Condition: timer==refresh_cycles, output slot free (!o_v || o_r), and no change emission in the same cycle.
  - Action: load the slot with ref_d and o_refresh=1, and clear timer.
- Effective states:
  - NOREF (have_ref=0): only change emission is possible.
  - TRACK (timer<refresh_cycles).
  - DUE (timer==refresh_cycles): refresh is pending until the slot frees.
- Simultaneous events:
  - Change accept while DUE: the change wins, the refresh is cancelled, timer clears.
  - Redundant accept while DUE with slot free: the sample is dropped and the refresh is emitted.
  - Output pop plus a new emission in the same cycle: the slot reloads back-to-back and o_v stays 1.
- Steady state with o_r=1 and no changes: refresh o_v pulses every refresh_cycles+1 cycles.
- Backpressure (o_v=1, o_r=0): i_r=0, no refresh is emitted, timer saturates.
- Reset mid-operation: any pending output is discarded, have_ref clears, and the next accepted value is always forwarded.
- Comparison covers all width bits; there is no masking.

Decomposition:
- Shared package base_pkg holds:
  - a clog2 helper function;
  - a localparam helper for the timer width.
- No enum typedef is required; the states are implied by have_ref and timer.
- One natural sub-module is base_aoreg: a single-entry valid/ready output register of width+1 bits (data plus refresh flag) with load/pop semantics and o_v reset to 0. It is reusable by other base_ cells.

Test Plan:
1. width=8, refresh_cycles=0, o_r=1; stream 0x11,0x11,0x22,0x22,0x11 with i_v=1 each cycle -> outputs exactly 0x11,0x22,0x11; o_refresh=0 throughout; i_r=1 every cycle.
2. width=8, refresh_cycles=4, o_r=1; single 0x5A then i_v=0 -> o_v at cycle 1 (o_refresh=0), then refresh 0x5A at cycles 6, 11, 16 with o_refresh=1.
3. refresh_cycles=4; send 0x5A, hold i_v=1 with 0x5A, and at the cycle the refresh is due present 0x7E -> 0x7E emitted with o_refresh=0, no 0x5A refresh that cycle; next refresh is 0x7E five cycles later.
4. Backpressure: o_v=1 with 0x33, o_r=0 for 10 cycles, refresh_cycles=4 -> i_r=0, o_d stable at 0x33, no new load; on o_r=1 the pop occurs and the refresh 0x33 (o_refresh=1) appears the next cycle.
5. Reset asserted for 1 cycle while o_v=1 holding 0x44, then send 0x44 -> o_v=0 after reset, i_r=0 during reset; 0x44 is forwarded (have_ref was cleared), o_refresh=0.
6. Back-to-back: o_r=1, stream 0x01,0x02,0x03 on consecutive cycles -> o_v stays 1 for three consecutive cycles with o_d 0x01,0x02,0x03; no bubbles.
